// File: rtl/register_file_pkg.sv
// Shared types and constants for the stack register file.
// Build option: REGISTER_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
package register_file_pkg;

    localparam int unsigned STACK_OP_WIDTH         = 2;
    localparam int unsigned STACK_REGISTER_ADDRESS = 0;

    typedef enum logic [STACK_OP_WIDTH-1:0] {
        STACK_NONE = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } stack_op_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Register 0 of the register file: stack pointer with load / push / pop priority,
// bounds checking and sticky flags. Next-value outputs exist only with REGISTER_FILE_BYPASS_EN.
module stack_pointer_unit
    import register_file_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 2,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] STACK_BASE  = {DATA_WIDTH{1'b1}},
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stack_write_enable,
    input  logic [STACK_OP_WIDTH-1:0] stack_op,
    input  logic [DATA_WIDTH-1:0]     stack_register_write_data,
    input  logic                      general_register_write_enable,
    input  logic [ADDRESS_WIDTH-1:0]  address_3,
    input  logic [DATA_WIDTH-1:0]     general_register_write_data,
    input  logic                      stack_flag_clear,
`ifdef REGISTER_FILE_BYPASS_EN
    output logic                      sp_write_c,
    output logic [DATA_WIDTH-1:0]     sp_next_c,
`endif
    output logic [DATA_WIDTH-1:0]     stack_pointer,
    output logic                      stack_overflow,
    output logic                      stack_underflow
);

    logic                  push_c;
    logic                  pop_c;
    logic                  general_hit_c;
    logic                  at_limit_c;
    logic                  at_base_c;
    logic                  write_c;
    logic [DATA_WIDTH-1:0] next_c;
    logic                  overflow_set_c;
    logic                  underflow_set_c;

    // Decode of the three competing register-0 sources
    always_comb begin
        push_c        = (stack_op == STACK_PUSH);
        pop_c         = (stack_op == STACK_POP);
        general_hit_c = general_register_write_enable
                        && (address_3 == ADDRESS_WIDTH'(STACK_REGISTER_ADDRESS));
        at_limit_c    = (stack_pointer == STACK_LIMIT);
        at_base_c     = (stack_pointer == STACK_BASE);
    end

    // Priority: load > push/pop > general write; a blocked push/pop holds SP
    always_comb begin
        write_c         = 1'b0;
        next_c          = stack_pointer;
        overflow_set_c  = 1'b0;
        underflow_set_c = 1'b0;
        if (stack_write_enable) begin
            write_c = 1'b1;
            next_c  = stack_register_write_data;
        end else if (push_c) begin
            if (at_limit_c) begin
                overflow_set_c = 1'b1;
            end else begin
                write_c = 1'b1;
                next_c  = stack_pointer - DATA_WIDTH'(1);
            end
        end else if (pop_c) begin
            if (at_base_c) begin
                underflow_set_c = 1'b1;
            end else begin
                write_c = 1'b1;
                next_c  = stack_pointer + DATA_WIDTH'(1);
            end
        end else if (general_hit_c) begin
            write_c = 1'b1;
            next_c  = general_register_write_data;
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    assign sp_write_c = write_c;
    assign sp_next_c  = next_c;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stack_pointer <= STACK_BASE;
        end else if (write_c) begin
            stack_pointer <= next_c;
        end
    end

    // Sticky flags: a violation in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (overflow_set_c) begin
                stack_overflow <= 1'b1;
            end else if (stack_flag_clear) begin
                stack_overflow <= 1'b0;
            end
            if (underflow_set_c) begin
                stack_underflow <= 1'b1;
            end else if (stack_flag_clear) begin
                stack_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stack_register_file.sv
// Register file: register 0 is the stack pointer unit, registers 1..N-1 are general.
// Two combinational read ports; REGISTER_FILE_BYPASS_EN forwards same-cycle writes to reads.
module stack_register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 2,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] STACK_BASE  = {DATA_WIDTH{1'b1}},
    parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      general_register_write_enable,
    input  logic                      stack_write_enable,
    input  logic [STACK_OP_WIDTH-1:0] stack_op,
    input  logic [ADDRESS_WIDTH-1:0]  address_1,
    input  logic [ADDRESS_WIDTH-1:0]  address_2,
    input  logic [ADDRESS_WIDTH-1:0]  address_3,
    input  logic [DATA_WIDTH-1:0]     general_register_write_data,
    input  logic [DATA_WIDTH-1:0]     stack_register_write_data,
    input  logic                      stack_flag_clear,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    output logic [DATA_WIDTH-1:0]     stack_pointer,
    output logic                      stack_overflow,
    output logic                      stack_underflow
);

    localparam int unsigned NUM_REGISTERS = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] register_view [NUM_REGISTERS];

`ifdef REGISTER_FILE_BYPASS_EN
    logic                  sp_write_c;
    logic [DATA_WIDTH-1:0] sp_next_c;
`endif

    stack_pointer_unit #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .STACK_BASE    (STACK_BASE),
        .STACK_LIMIT   (STACK_LIMIT)
    ) u_stack_pointer_unit (
        .clk                           (clk),
        .reset_n                       (reset_n),
        .stack_write_enable            (stack_write_enable),
        .stack_op                      (stack_op),
        .stack_register_write_data     (stack_register_write_data),
        .general_register_write_enable (general_register_write_enable),
        .address_3                     (address_3),
        .general_register_write_data   (general_register_write_data),
        .stack_flag_clear              (stack_flag_clear),
`ifdef REGISTER_FILE_BYPASS_EN
        .sp_write_c                    (sp_write_c),
        .sp_next_c                     (sp_next_c),
`endif
        .stack_pointer                 (stack_pointer),
        .stack_overflow                (stack_overflow),
        .stack_underflow               (stack_underflow)
    );

    assign register_view[STACK_REGISTER_ADDRESS] = stack_pointer;

    // General registers are unaffected by stack activity in the same cycle
    for (genvar g = 1; g < NUM_REGISTERS; g++) begin : gen_general_register
        logic [DATA_WIDTH-1:0] value_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                value_q <= '0;
            end else if (general_register_write_enable
                         && (address_3 == ADDRESS_WIDTH'(g))) begin
                value_q <= general_register_write_data;
            end
        end

        assign register_view[g] = value_q;
    end

    always_comb begin
        read_data_1 = register_view[address_1];
        read_data_2 = register_view[address_2];
`ifdef REGISTER_FILE_BYPASS_EN
        // Forward only the write that actually wins for the addressed register
        if (address_1 == ADDRESS_WIDTH'(STACK_REGISTER_ADDRESS)) begin
            if (sp_write_c) begin
                read_data_1 = sp_next_c;
            end
        end else if (general_register_write_enable && (address_3 == address_1)) begin
            read_data_1 = general_register_write_data;
        end
        if (address_2 == ADDRESS_WIDTH'(STACK_REGISTER_ADDRESS)) begin
            if (sp_write_c) begin
                read_data_2 = sp_next_c;
            end
        end else if (general_register_write_enable && (address_3 == address_2)) begin
            read_data_2 = general_register_write_data;
        end
`endif
    end

endmodule

// File: tb/tb_stack_register_file.sv
// Randomized and directed bench for stack_register_file against an array-based model.
module tb_stack_register_file;
    import register_file_pkg::*;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          general_register_write_enable;
    logic          stack_write_enable;
    logic [1:0]    stack_op;
    logic [AW-1:0] address_1, address_2, address_3;
    logic [DW-1:0] general_register_write_data;
    logic [DW-1:0] stack_register_write_data;
    logic          stack_flag_clear;
    logic [DW-1:0] read_data_1, read_data_2, stack_pointer;
    logic          stack_overflow, stack_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg [NR];
    logic [DW-1:0] nx_reg [NR];
    logic          m_ovf, m_unf, nx_ovf, nx_unf;

    stack_register_file #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .STACK_BASE    (8'hFF),
        .STACK_LIMIT   (8'h00)
    ) dut (
        .clk                           (clk),
        .reset_n                       (reset_n),
        .general_register_write_enable (general_register_write_enable),
        .stack_write_enable            (stack_write_enable),
        .stack_op                      (stack_op),
        .address_1                     (address_1),
        .address_2                     (address_2),
        .address_3                     (address_3),
        .general_register_write_data   (general_register_write_data),
        .stack_register_write_data     (stack_register_write_data),
        .stack_flag_clear              (stack_flag_clear),
        .read_data_1                   (read_data_1),
        .read_data_2                   (read_data_2),
        .stack_pointer                 (stack_pointer),
        .stack_overflow                (stack_overflow),
        .stack_underflow               (stack_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < int'(NR); i++) m_reg[i] = 8'h00;
        m_reg[0] = 8'hFF;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Next state from the current model state and the inputs being driven
    function automatic void model_next();
        nx_reg = m_reg;
        nx_ovf = m_ovf;
        nx_unf = m_unf;
        if (stack_flag_clear) begin
            nx_ovf = 1'b0;
            nx_unf = 1'b0;
        end
        if (stack_write_enable) begin
            nx_reg[0] = stack_register_write_data;
        end else if (stack_op == 2'd1) begin
            if (m_reg[0] == 8'h00) nx_ovf = 1'b1;
            else nx_reg[0] = m_reg[0] - 8'd1;
        end else if (stack_op == 2'd2) begin
            if (m_reg[0] == 8'hFF) nx_unf = 1'b1;
            else nx_reg[0] = m_reg[0] + 8'd1;
        end else if (general_register_write_enable && address_3 == 2'd0) begin
            nx_reg[0] = general_register_write_data;
        end
        if (general_register_write_enable && address_3 != 2'd0)
            nx_reg[address_3] = general_register_write_data;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        model_next();
`ifdef REGISTER_FILE_BYPASS_EN
        return nx_reg[a];
`else
        return m_reg[a];
`endif
    endfunction

    task automatic idle_inputs();
        general_register_write_enable = 1'b0;
        stack_write_enable            = 1'b0;
        stack_op                      = 2'd0;
        address_3                     = 2'd0;
        general_register_write_data   = 8'h00;
        stack_register_write_data     = 8'h00;
        stack_flag_clear              = 1'b0;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_reg = nx_reg;
        m_ovf = nx_ovf;
        m_unf = nx_unf;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        address_1 = 2'd1;
        address_2 = 2'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stack_pointer !== 8'hFF) begin
            errors++; $display("FAIL reset_sp actual=%h expected=%h", stack_pointer, 8'hFF);
        end
        checks++;
        if ({stack_overflow, stack_underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_flags actual=%b expected=00", {stack_overflow, stack_underflow});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (read_data_1 !== 8'h00 || read_data_2 !== 8'h00) begin
            errors++; $display("FAIL reset_read12 actual=%h,%h expected=00,00", read_data_1, read_data_2);
        end
        address_1 = 2'd3;
        #1;
        checks++;
        if (read_data_1 !== 8'h00) begin
            errors++; $display("FAIL reset_read3 actual=%h expected=00", read_data_1);
        end
        // Commit a value, then abort a second write and a push with reset
        address_1 = 2'd1;
        general_register_write_enable = 1'b1;
        address_3 = 2'd1;
        general_register_write_data = 8'h77;
        tick();
        checks++;
        if (read_data_1 !== 8'h77) begin
            errors++; $display("FAIL prereset_write actual=%h expected=77", read_data_1);
        end
        general_register_write_data = 8'hAA;
        stack_op = 2'd1;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (read_data_1 !== 8'h00 || stack_pointer !== 8'hFF) begin
            errors++; $display("FAIL async_reset actual=%h sp=%h expected=00 sp=ff", read_data_1, stack_pointer);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data_1 !== 8'h00 || stack_pointer !== 8'hFF) begin
            errors++; $display("FAIL reset_hold actual=%h sp=%h expected=00 sp=ff", read_data_1, stack_pointer);
        end
        idle_inputs();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_general_write();
        general_register_write_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            address_3 = AW'(i);
            general_register_write_data = DW'(i * 17);
            tick();
        end
        idle_inputs();
        address_1 = 2'd1;
        address_2 = 2'd2;
        #1;
        checks++;
        if (read_data_1 !== 8'h11 || read_data_2 !== 8'h22) begin
            errors++; $display("FAIL read_pair_1_2 actual=%h,%h expected=11,22", read_data_1, read_data_2);
        end
        address_1 = 2'd3;
        address_2 = 2'd3;
        #1;
        checks++;
        if (read_data_1 !== 8'h33 || read_data_2 !== 8'h33) begin
            errors++; $display("FAIL read_pair_3_3 actual=%h,%h expected=33,33", read_data_1, read_data_2);
        end
    endtask

    task automatic test_underflow_push();
        stack_op = 2'd2;
        tick();
        checks++;
        if (stack_underflow !== 1'b1 || stack_pointer !== 8'hFF) begin
            errors++; $display("FAIL pop_at_base actual=unf%b sp=%h expected=unf1 sp=ff", stack_underflow, stack_pointer);
        end
        stack_op = 2'd1;
        repeat (3) tick();
        checks++;
        if (stack_pointer !== 8'hFC) begin
            errors++; $display("FAIL push_three actual=%h expected=fc", stack_pointer);
        end
        idle_inputs();
        stack_flag_clear = 1'b1;
        tick();
        checks++;
        if (stack_underflow !== 1'b0) begin
            errors++; $display("FAIL flag_clear actual=%b expected=0", stack_underflow);
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        stack_write_enable = 1'b1;
        stack_register_write_data = 8'h00;
        tick();
        idle_inputs();
        stack_op = 2'd1;
        tick();
        checks++;
        if (stack_overflow !== 1'b1 || stack_pointer !== 8'h00) begin
            errors++; $display("FAIL push_at_limit actual=ovf%b sp=%h expected=ovf1 sp=00", stack_overflow, stack_pointer);
        end
        stack_flag_clear = 1'b1;
        tick();
        checks++;
        if (stack_overflow !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear actual=%b expected=1", stack_overflow);
        end
        idle_inputs();
        stack_flag_clear = 1'b1;
        tick();
        checks++;
        if (stack_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear actual=%b expected=0", stack_overflow);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        stack_write_enable = 1'b1;
        stack_register_write_data = 8'h40;
        stack_op = 2'd1;
        general_register_write_enable = 1'b1;
        address_3 = 2'd0;
        general_register_write_data = 8'h99;
        tick();
        checks++;
        if (stack_pointer !== 8'h40) begin
            errors++; $display("FAIL load_priority actual=%h expected=40", stack_pointer);
        end
        idle_inputs();
        stack_op = 2'd1;
        general_register_write_enable = 1'b1;
        address_3 = 2'd2;
        general_register_write_data = 8'hC3;
        tick();
        idle_inputs();
        address_2 = 2'd2;
        #1;
        checks++;
        if (stack_pointer !== 8'h3F || read_data_2 !== 8'hC3) begin
            errors++; $display("FAIL push_with_write actual=sp%h r2=%h expected=sp3f r2=c3", stack_pointer, read_data_2);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] expected;
        address_1 = 2'd1;
        address_2 = 2'd0;
        general_register_write_enable = 1'b1;
        address_3 = 2'd1;
        general_register_write_data = 8'h5A;
        stack_op = 2'd1;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        expected = 8'h5A;
`else
        expected = 8'h11;
`endif
        checks++;
        if (read_data_1 !== expected) begin
            errors++; $display("FAIL bypass_gen actual=%h expected=%h", read_data_1, expected);
        end
`ifdef REGISTER_FILE_BYPASS_EN
        expected = 8'h3E;
`else
        expected = 8'h3F;
`endif
        checks++;
        if (read_data_2 !== expected) begin
            errors++; $display("FAIL bypass_sp actual=%h expected=%h", read_data_2, expected);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (read_data_1 !== 8'h5A || read_data_2 !== 8'h3E) begin
            errors++; $display("FAIL post_edge actual=%h,%h expected=5a,3e", read_data_1, read_data_2);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            general_register_write_enable = ($urandom_range(0, 2) == 0);
            address_3 = AW'($urandom_range(0, 3));
            general_register_write_data = DW'($urandom);
            stack_write_enable = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: stack_register_write_data = DW'($urandom_range(0, 2));
                1: stack_register_write_data = DW'($urandom_range(253, 255));
                default: stack_register_write_data = DW'($urandom);
            endcase
            stack_op = 2'($urandom_range(0, 3));
            stack_flag_clear = ($urandom_range(0, 7) == 0);
            address_1 = AW'($urandom_range(0, 3));
            address_2 = AW'($urandom_range(0, 3));
            #1;
            e1 = exp_read(address_1);
            e2 = exp_read(address_2);
            checks++;
            if (read_data_1 !== e1 || read_data_2 !== e2) begin
                errors++; $display("FAIL rand_read n=%0d actual=%h,%h expected=%h,%h", n, read_data_1, read_data_2, e1, e2);
            end
            tick();
            checks++;
            if (stack_pointer !== m_reg[0] || stack_overflow !== m_ovf || stack_underflow !== m_unf) begin
                errors++; $display("FAIL rand_state n=%0d actual=sp%h o%b u%b expected=sp%h o%b u%b",
                                   n, stack_pointer, stack_overflow, stack_underflow, m_reg[0], m_ovf, m_unf);
            end
        end
        idle_inputs();
        for (int a = 0; a < int'(NR); a++) begin
            address_1 = AW'(a);
            #1;
            checks++;
            if (read_data_1 !== m_reg[a]) begin
                errors++; $display("FAIL rand_final reg%0d actual=%h expected=%h", a, read_data_1, m_reg[a]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        address_1 = 2'd0;
        address_2 = 2'd0;
        test_reset();
        test_general_write();
        test_underflow_push();
        test_overflow();
        test_priority();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_register_file.md
# stack_register_file

Parametrised next-generation register file for the microprocessor datapath: 2**ADDRESS_WIDTH registers of DATA_WIDTH bits, two combinational read ports, one synchronous general write port. Register 0 is a dedicated stack pointer with hardware push/pop adjust, bounds checking and sticky overflow/underflow flags. Sits between decode (addresses, control) and the ALU/load-store unit (operands, stack address).

## Interface
- ADDRESS_WIDTH, 2, register address width; 2**ADDRESS_WIDTH registers
- DATA_WIDTH, 8, register width in bits
- STACK_BASE, 2**DATA_WIDTH-1, stack pointer reset value and empty position (top)
- STACK_LIMIT, 0, lowest legal stack pointer value (full position)
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- general_register_write_enable  input  1  write general_register_write_data to address_3
- stack_write_enable  input  1  load stack_register_write_data into register 0
- stack_op  input  2  stack_op_t: NONE, PUSH, POP (fourth encoding treated as NONE)
- address_1, address_2  input  ADDRESS_WIDTH  read port addresses
- address_3  input  ADDRESS_WIDTH  write address
- general_register_write_data  input  DATA_WIDTH  general write data
- stack_register_write_data  input  DATA_WIDTH  stack pointer load value
- stack_flag_clear  input  1  clears both sticky flags
- read_data_1, read_data_2  output  DATA_WIDTH  combinational read data
- stack_pointer  output  DATA_WIDTH  current register 0 value
- stack_overflow, stack_underflow  output  1  sticky bounds-violation flags

## Operation
- Reset (reset_n low, asynchronous): registers 1..N-1 = 0; register 0 = STACK_BASE; both flags = 0. Read outputs follow reset contents immediately.
- Register 0 update priority per edge: stack_write_enable load > stack_op PUSH/POP > general write with address_3 == 0 (ignored when either higher source is active).
- PUSH: if SP == STACK_LIMIT, set stack_overflow, SP held; else SP <= SP - 1.
- POP: if SP == STACK_BASE, set stack_underflow, SP held; else SP <= SP + 1.
- Load wins over push/pop in same cycle; no bounds check on load (software responsibility). Arithmetic is DATA_WIDTH modulo, but bounds checks prevent wrap.
- General write to address 1..N-1 is independent of stack activity and proceeds in the same cycle.
- stack_flag_clear clears flags; if a violation occurs in the same cycle, set wins.
- Reads: read_data_k = register[address_k]; both ports may hit the same address.

## Timing
- Writes, loads, push/pop, flag updates: visible one rising edge after the control is sampled high.
- Reads: zero-latency combinational; without bypass, a same-cycle write returns the old value until the edge.
- Reset deassertion: first update on the first rising edge with reset_n high.
- reset_n assertion mid-operation aborts any pending write; state returns to reset values immediately.

## Configuration
- REGISTER_FILE_BYPASS_EN defined: read port whose address matches a same-cycle winning write to that register returns the value to be written (general write data, stack load data, or SP±1 for a legal push/pop) combinationally.
- Not defined: no forwarding; reads always return stored contents.

## Structure
- register_file_pkg: stack_op_t enum (STACK_NONE, STACK_PUSH, STACK_POP), STACK_REGISTER_ADDRESS = 0 constant.
- Sub-module stack_pointer_unit: register 0, priority mux, bounds compare, sticky flags, next-value output used for bypass. Top level holds registers 1..N-1 and read/bypass muxes.

## Test plan
- Reset with defaults: stack_pointer = 255, all reads of addresses 1..3 = 0, flags 0; assert reset_n low mid-write -> write lost, values return to reset immediately.
- Write 0x11/0x22/0x33 to addresses 1/2/3, then read pairs (1,2),(3,3) -> 0x11,0x22 then 0x33,0x33.
- POP at SP = 255 -> stack_underflow = 1, SP stays 255; PUSH three times -> SP = 252; stack_flag_clear -> underflow 0.
- Load SP = 0 (STACK_LIMIT) then PUSH -> stack_overflow = 1, SP = 0; same cycle stack_flag_clear + violating PUSH -> flag remains 1.
- Same cycle: stack_write_enable (0x40), PUSH, general write 0x99 to address 0 -> SP = 0x40; general write to address 2 alongside PUSH -> both take effect.
- With REGISTER_FILE_BYPASS_EN: write 0x5A to address 1 while address_1 = 1 -> read_data_1 = 0x5A before edge; without macro -> old value until edge.
